// File: rtl/collision_judge.sv
// collision_judge: per-frame Mario/barrel collision and scoring stage.
// Samples both sprite positions on frame_tick. At the following edge it checks
// for a bounding-box overlap (a hit) and for a barrel passing from one side of
// Mario to the other (a score). It also tracks lives, score and game phase.
// Ports:
//   CLOCK_50   - system clock
//   resetn     - asynchronous active-low reset
//   start      - game-enable level; low returns the game to IDLE
//   frame_tick - one-cycle pulse per frame; positions valid while high
//   mar_x/y    - Mario top-left position
//   bar_x/y    - barrel top-left position
//   lives      - remaining lives
//   score      - barrels cleared, saturating at 255
//   hit        - one-cycle pulse on a counted collision
//   playing    - high in PLAY or COOL
//   game_over  - high in OVER
module collision_judge #(
   parameter int unsigned MAR_W      = 4,
   parameter int unsigned MAR_H      = 4,
   parameter int unsigned BAR_W      = 4,
   parameter int unsigned BAR_H      = 4,
   parameter int unsigned LIVES_INIT = 3,
   parameter int unsigned COOLDOWN   = 25000000,
   parameter int unsigned CNT_W      = 25
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       start,
   input  logic       frame_tick,
   input  logic [7:0] mar_x,
   input  logic [6:0] mar_y,
   input  logic [7:0] bar_x,
   input  logic [6:0] bar_y,
   output logic [1:0] lives,
   output logic [7:0] score,
   output logic       hit,
   output logic       playing,
   output logic       game_over
);

   typedef enum logic [1:0] {StIdle, StPlay, StCool, StOver} state_e;
   typedef enum logic [1:0] {SideNone, SideLeft, SideRight, SideMid} side_e;

   state_e           state_q;
   side_e            side;
   side_e            last_side_q;
   logic             hit_since_side_q;
   logic [CNT_W-1:0] cnt_q;

   logic [7:0] mar_x_q, bar_x_q;
   logic [6:0] mar_y_q, bar_y_q;
   logic       eval_q;

   // Widened by one bit so that the right/bottom edges never wrap.
   logic [8:0] mar_x_end, bar_x_end, mar_x_w, bar_x_w;
   logic [7:0] mar_y_end, bar_y_end, mar_y_w, bar_y_w;
   logic       overlap;

   assign mar_x_w   = {1'b0, mar_x_q};
   assign bar_x_w   = {1'b0, bar_x_q};
   assign mar_y_w   = {1'b0, mar_y_q};
   assign bar_y_w   = {1'b0, bar_y_q};
   assign mar_x_end = mar_x_w + 9'(MAR_W);
   assign bar_x_end = bar_x_w + 9'(BAR_W);
   assign mar_y_end = mar_y_w + 8'(MAR_H);
   assign bar_y_end = bar_y_w + 8'(BAR_H);

   assign overlap = (mar_x_w < bar_x_end) && (bar_x_w < mar_x_end) &&
                    (mar_y_w < bar_y_end) && (bar_y_w < mar_y_end);

   always_comb begin
      side = SideMid;
      if (bar_x_end <= mar_x_w) begin
         side = SideLeft;
      end else if (bar_x_w >= mar_x_end) begin
         side = SideRight;
      end
   end

   // Position capture; eval marks the cycle in which the copies are judged.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         mar_x_q <= '0;
         mar_y_q <= '0;
         bar_x_q <= '0;
         bar_y_q <= '0;
         eval_q  <= 1'b0;
      end else begin
         eval_q <= frame_tick;
         if (frame_tick) begin
            mar_x_q <= mar_x;
            mar_y_q <= mar_y;
            bar_x_q <= bar_x;
            bar_y_q <= bar_y;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q          <= StIdle;
         lives            <= 2'(LIVES_INIT);
         score            <= '0;
         hit              <= 1'b0;
         playing          <= 1'b0;
         game_over        <= 1'b0;
         cnt_q            <= '0;
         last_side_q      <= SideNone;
         hit_since_side_q <= 1'b0;
      end else begin
         hit <= 1'b0;
         if (!start && state_q != StIdle) begin
            // Abort wins over any overlap judged in the same cycle.
            state_q   <= StIdle;
            lives     <= 2'(LIVES_INIT);
            score     <= '0;
            playing   <= 1'b0;
            game_over <= 1'b0;
            cnt_q     <= '0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  lives     <= 2'(LIVES_INIT);
                  score     <= '0;
                  playing   <= 1'b0;
                  game_over <= 1'b0;
                  if (start) begin
                     state_q          <= StPlay;
                     playing          <= 1'b1;
                     last_side_q      <= SideNone;
                     hit_since_side_q <= 1'b0;
                  end
               end
               StPlay: begin
                  if (eval_q) begin
                     // An overlap is always MID, so a hit never coincides with scoring.
                     if (overlap) begin
                        hit              <= 1'b1;
                        lives            <= lives - 2'd1;
                        hit_since_side_q <= 1'b1;
                        if (lives == 2'd1) begin
                           state_q   <= StOver;
                           playing   <= 1'b0;
                           game_over <= 1'b1;
                        end else begin
                           state_q <= StCool;
                           cnt_q   <= CNT_W'(COOLDOWN - 1);
                        end
                     end else if (side != SideMid) begin
                        if (last_side_q != SideNone && side != last_side_q &&
                            !hit_since_side_q && score != 8'hFF) begin
                           score <= score + 8'd1;
                        end
                        last_side_q      <= side;
                        hit_since_side_q <= 1'b0;
                     end
                  end
               end
               StCool: begin
                  // Side tracking continues so a crossing made here is never scored.
                  if (eval_q && side != SideMid) begin
                     last_side_q      <= side;
                     hit_since_side_q <= 1'b0;
                  end
                  if (cnt_q == '0) begin
                     state_q <= StPlay;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
               StOver: begin
                  lives     <= 2'd0;
                  game_over <= 1'b1;
                  playing   <= 1'b0;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_collision_judge.sv
// tb_collision_judge: directed self-checking bench for collision_judge.
// Mario sits at (40,100); the barrel is placed per frame to produce hits,
// side changes, cooldown behaviour, score saturation and an async reset.
module tb_collision_judge;

   logic       CLOCK_50;
   logic       resetn;
   logic       start;
   logic       frame_tick;
   logic [7:0] mar_x;
   logic [6:0] mar_y;
   logic [7:0] bar_x;
   logic [6:0] bar_y;
   logic [1:0] lives;
   logic [7:0] score;
   logic       hit;
   logic       playing;
   logic       game_over;

   int total;
   int bad;

   collision_judge #(
      .MAR_W     (4),
      .MAR_H     (4),
      .BAR_W     (4),
      .BAR_H     (4),
      .LIVES_INIT(3),
      .COOLDOWN  (16),
      .CNT_W     (25)
   ) dut (
      .CLOCK_50  (CLOCK_50),
      .resetn    (resetn),
      .start     (start),
      .frame_tick(frame_tick),
      .mar_x     (mar_x),
      .mar_y     (mar_y),
      .bar_x     (bar_x),
      .bar_y     (bar_y),
      .lives     (lives),
      .score     (score),
      .hit       (hit),
      .playing   (playing),
      .game_over (game_over)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit past the next rising edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLOCK_50);
         #1;
      end
   endtask

   // Present one frame; returns just after the judging edge, when hit is visible.
   task automatic do_frame(input logic [7:0] x, input logic [6:0] y);
      bar_x      = x;
      bar_y      = y;
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      step(1);
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      resetn     = 1'b0;
      start      = 1'b0;
      frame_tick = 1'b0;
      mar_x      = 8'd40;
      mar_y      = 7'd100;
      bar_x      = 8'd0;
      bar_y      = 7'd0;
      #12;
      resetn = 1'b1;
      step(1);

      // 1: reset values, ticks ignored while idle
      chk("rst_lives", lives, 3);
      chk("rst_score", score, 0);
      chk("rst_hit", hit, 0);
      chk("rst_playing", playing, 0);
      chk("rst_over", game_over, 0);
      do_frame(8'd42, 7'd101);
      chk("idle_hit", hit, 0);
      chk("idle_lives", lives, 3);

      // 2: first hit, cooldown ignore, hit after cooldown
      start = 1'b1;
      step(1);
      chk("start_playing", playing, 1);
      do_frame(8'd42, 7'd101);
      chk("hit1", hit, 1);
      chk("hit1_lives", lives, 2);
      chk("hit1_playing", playing, 1);
      step(1);
      chk("hit1_pulse_end", hit, 0);
      step(3);
      do_frame(8'd42, 7'd101);
      chk("cool_hit", hit, 0);
      chk("cool_lives", lives, 2);
      step(14);
      do_frame(8'd42, 7'd101);
      chk("hit2", hit, 1);
      chk("hit2_lives", lives, 1);

      // 3: last life, game over, restart
      step(20);
      do_frame(8'd42, 7'd101);
      chk("hit3", hit, 1);
      chk("over_lives", lives, 0);
      chk("over_flag", game_over, 1);
      chk("over_playing", playing, 0);
      start = 1'b0;
      step(1);
      chk("idle_lives_restore", lives, 3);
      chk("idle_score_restore", score, 0);
      chk("idle_over_clear", game_over, 0);
      start = 1'b1;
      step(1);
      chk("restart_playing", playing, 1);

      // 4: pass-overs RIGHT -> MID -> LEFT -> MID -> RIGHT
      do_frame(8'd50, 7'd100);
      chk("pass_r_score", score, 0);
      do_frame(8'd41, 7'd90);
      chk("pass_mid_hit", hit, 0);
      chk("pass_mid_score", score, 0);
      do_frame(8'd30, 7'd100);
      chk("pass_l_score", score, 1);
      chk("pass_l_hit", hit, 0);
      do_frame(8'd41, 7'd90);
      do_frame(8'd50, 7'd100);
      chk("pass_back_score", score, 2);

      // 5: a hit between sides cancels the pass-over
      do_frame(8'd50, 7'd100);
      chk("hp_r_score", score, 2);
      do_frame(8'd41, 7'd100);
      chk("hp_hit", hit, 1);
      chk("hp_lives", lives, 2);
      step(20);
      do_frame(8'd30, 7'd100);
      chk("hp_l_score", score, 2);
      chk("hp_l_hit", hit, 0);
      chk("hp_playing", playing, 1);

      // 6: saturation; last side is LEFT so every frame below is a crossing
      for (int i = 0; i < 300; i++) begin
         do_frame((i % 2 == 0) ? 8'd50 : 8'd30, 7'd100);
         if (i == 251) chk("sat_254", score, 254);
         if (i == 252) chk("sat_255", score, 255);
      end
      chk("sat_hold", score, 255);

      // Async reset during the hit pulse / cooldown
      do_frame(8'd41, 7'd100);
      chk("pre_rst_hit", hit, 1);
      chk("pre_rst_lives", lives, 1);
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_lives", lives, 3);
      chk("arst_score", score, 0);
      chk("arst_hit", hit, 0);
      chk("arst_playing", playing, 0);
      chk("arst_over", game_over, 0);
      #1;
      resetn = 1'b1;
      step(1);
      chk("post_rst_playing", playing, 1);
      do_frame(8'd42, 7'd101);
      chk("post_rst_hit", hit, 1);
      chk("post_rst_lives", lives, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
